// File: rtl/ow_slot_engine_pkg.sv
// Shared types and default slot timings (microseconds) for the 1-Wire slot engine.
package ow_pkg;

  // Bit operation requested by the upstream serialiser.
  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_RESET   = 2'b10,
    OP_ILLEGAL = 2'b11
  } ow_op_e;

  // Slot sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOW  = 3'd1,
    ST_HIGH = 3'd2,
    ST_REC  = 3'd3,
    ST_DONE = 3'd4
  } ow_state_e;

  // Latched command payload.
  typedef struct packed {
    ow_op_e op;
    logic   wbit;
  } ow_cmd_t;

  localparam int unsigned CLK_PER_US_DEF = 50;
  localparam int unsigned T_LOW1_US      = 6;
  localparam int unsigned T_LOW0_US      = 60;
  localparam int unsigned T_SLOT_US      = 65;
  localparam int unsigned T_REC_US       = 5;
  localparam int unsigned T_RDS_US       = 15;
  localparam int unsigned T_RSTL_US      = 480;
  localparam int unsigned T_PDS_US       = 70;
  localparam int unsigned T_RSTH_US      = 480;

  // True when the op actually touches the bus (illegal ops, and reads without the read slot, do not).
  function automatic logic op_uses_bus(input ow_op_e op, input logic read_en);
    logic uses;
    uses = 1'b0;
    case (op)
      OP_WRITE: uses = 1'b1;
      OP_RESET: uses = 1'b1;
      OP_READ:  uses = read_en;
      default:  uses = 1'b0;
    endcase
    return uses;
  endfunction

endpackage

// File: rtl/ow_slot_engine_if.sv
// Command/response handshake between the serialiser and the slot engine.
interface ow_slot_engine_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_bit;
  logic       rsp_valid;
  logic       rsp_bit;
  logic       presence;
  logic       busy;

  modport master (
    output cmd_valid, cmd_op, cmd_bit,
    input  cmd_ready, rsp_valid, rsp_bit, presence, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_bit,
    output cmd_ready, rsp_valid, rsp_bit, presence, busy
  );
endinterface

// File: rtl/ow_slot_engine_in_sync.sv
// Two-flop synchroniser for the raw 1-Wire bus level; resets to the idle-high level.
module ow_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  // Metastability stage followed by the usable stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/ow_slot_engine.sv
// 1-Wire bit-slot timing generator: write/read slots and reset/presence sequences.
// Optional feature macro: OW_READ_SLOT_EN (when undefined, op 01 is treated as illegal
// and the read-sample logic is absent).
module ow_slot_engine
  import ow_pkg::*;
#(
  parameter int unsigned CLK_PER_US = CLK_PER_US_DEF,
  parameter int unsigned T_LOW1     = T_LOW1_US,
  parameter int unsigned T_LOW0     = T_LOW0_US,
  parameter int unsigned T_SLOT     = T_SLOT_US,
  parameter int unsigned T_REC      = T_REC_US,
`ifdef OW_READ_SLOT_EN
  parameter int unsigned T_RDS      = T_RDS_US,
`endif
  parameter int unsigned T_RSTL     = T_RSTL_US,
  parameter int unsigned T_PDS      = T_PDS_US,
  parameter int unsigned T_RSTH     = T_RSTH_US
) (
  input  logic              clk,
  input  logic              rst,
  ow_slot_engine_if.slave   ctl,
  input  logic              ow_in,
  output logic              ow_drive_low
);

  localparam int unsigned CNT_W       = $clog2((T_RSTL + T_RSTH) * CLK_PER_US + 1);
  localparam int unsigned LOW1_CYC    = T_LOW1 * CLK_PER_US;
  localparam int unsigned LOW0_CYC    = T_LOW0 * CLK_PER_US;
  localparam int unsigned RSTL_CYC    = T_RSTL * CLK_PER_US;
  localparam int unsigned SLOT_CYC    = T_SLOT * CLK_PER_US;
  localparam int unsigned SLOTREC_CYC = (T_SLOT + T_REC) * CLK_PER_US;
  localparam int unsigned PDS_AT      = (T_RSTL + T_PDS) * CLK_PER_US;
  localparam int unsigned RST_END     = (T_RSTL + T_RSTH) * CLK_PER_US;
`ifdef OW_READ_SLOT_EN
  localparam int unsigned RDS_CYC     = T_RDS * CLK_PER_US;
  localparam logic        READ_EN     = 1'b1;
`else
  localparam logic        READ_EN     = 1'b0;
`endif

  ow_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, low_last;
  ow_cmd_t          cmd_q, cmd_d;
  logic             ow_sync;
  logic             pres_q, pres_d;
  logic             drive_q, drive_d;
  logic             rv_q, rv_d;
  logic             rbit_q, rbit_d;
  logic             ready_q, ready_d;
  logic             busy_q;
  logic             accept;
`ifdef OW_READ_SLOT_EN
  logic             samp_q, samp_d;
`endif

  ow_in_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ow_in),
    .q   (ow_sync)
  );

  assign accept = ctl.cmd_valid && ready_q;

  // Last counter value of the low phase for the latched op.
  always_comb begin
    low_last = CNT_W'(LOW1_CYC - 1);
    if (cmd_q.op == OP_RESET) begin
      low_last = CNT_W'(RSTL_CYC - 1);
    end else if (cmd_q.op == OP_WRITE && !cmd_q.wbit) begin
      low_last = CNT_W'(LOW0_CYC - 1);
    end
  end

  // Next-state and next-output decode; counter runs from the slot start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    cmd_d   = cmd_q;
    pres_d  = pres_q;
    drive_d = 1'b0;
    rv_d    = 1'b0;
    rbit_d  = rbit_q;
`ifdef OW_READ_SLOT_EN
    samp_d  = samp_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = cnt_q;
        if (accept) begin
          cmd_d   = '{op: ow_op_e'(ctl.cmd_op), wbit: ctl.cmd_bit};
          cnt_d   = '0;
          state_d = ST_LOW;
          drive_d = op_uses_bus(ow_op_e'(ctl.cmd_op), READ_EN);
        end
      end
      ST_LOW: begin
        if (!op_uses_bus(cmd_q.op, READ_EN)) begin
          state_d = ST_DONE;
          rv_d    = 1'b1;
          rbit_d  = 1'b0;
        end else if (cnt_q == low_last) begin
          state_d = ST_HIGH;
        end else begin
          drive_d = 1'b1;
        end
      end
      ST_HIGH: begin
        if (cmd_q.op == OP_RESET) begin
          if (cnt_q == CNT_W'(PDS_AT)) begin
            pres_d = ~ow_sync;
          end
          if (cnt_q == CNT_W'(RST_END - 1)) begin
            state_d = ST_DONE;
            rv_d    = 1'b1;
            rbit_d  = pres_q;
          end
        end else begin
`ifdef OW_READ_SLOT_EN
          if (cmd_q.op == OP_READ && cnt_q == CNT_W'(RDS_CYC)) begin
            samp_d = ow_sync;
          end
`endif
          if (cnt_q == CNT_W'(SLOT_CYC - 1)) begin
            state_d = ST_REC;
          end
        end
      end
      ST_REC: begin
        if (cnt_q == CNT_W'(SLOTREC_CYC - 1)) begin
          state_d = ST_DONE;
          rv_d    = 1'b1;
`ifdef OW_READ_SLOT_EN
          rbit_d  = (cmd_q.op == OP_READ) ? samp_q : cmd_q.wbit;
`else
          rbit_d  = cmd_q.wbit;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      pres_q  <= 1'b0;
      drive_q <= 1'b0;
      rv_q    <= 1'b0;
      rbit_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
`ifdef OW_READ_SLOT_EN
      samp_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      pres_q  <= pres_d;
      drive_q <= drive_d;
      rv_q    <= rv_d;
      rbit_q  <= rbit_d;
      ready_q <= ready_d;
      busy_q  <= ~ready_d;
`ifdef OW_READ_SLOT_EN
      samp_q  <= samp_d;
`endif
    end
  end

  assign ow_drive_low  = drive_q;
  assign ctl.cmd_ready = ready_q;
  assign ctl.busy      = busy_q;
  assign ctl.rsp_valid = rv_q;
  assign ctl.rsp_bit   = rbit_q;
  assign ctl.presence  = pres_q;

endmodule

// File: tb/tb_ow_slot_engine.sv
// Bench for ow_slot_engine at CLK_PER_US=4 with a slot-timing model and directed ops.
`timescale 1ns/1ps
module tb_ow_slot_engine;

  localparam int C = 4;
`ifdef OW_READ_SLOT_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ow_in;
  logic ow_drive_low;
  logic slave_pull;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  // Slave pull-down window, in cycles relative to accept.
  bit   p_en = 1'b0;
  int   p_lo = 0;
  int   p_hi = 0;
  int   s_acc = 0;

  ow_slot_engine_if ctl ();

  ow_slot_engine #(.CLK_PER_US(C)) dut (
    .clk          (clk),
    .rst          (rst),
    .ctl          (ctl),
    .ow_in        (ow_in),
    .ow_drive_low (ow_drive_low)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign slave_pull = p_en && ((cyc - s_acc) >= p_lo) && ((cyc - s_acc) <= p_hi);
  assign ow_in = ~(ow_drive_low | slave_pull);

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---- behavioural model: outputs as a function of cycles since accept ----
  function automatic bit uses(input logic [1:0] op);
    return (op == 2'b00) || (op == 2'b10) || (READ_EN && op == 2'b01);
  endfunction

  function automatic int low_len(input logic [1:0] op, input logic b);
    if (!uses(op)) return 0;
    if (op == 2'b10) return 480 * C;
    if (op == 2'b00 && !b) return 60 * C;
    return 6 * C;
  endfunction

  function automatic int lat(input logic [1:0] op);
    if (!uses(op)) return 2;
    if (op == 2'b10) return (480 + 480) * C + 1;
    return (65 + 5) * C + 1;
  endfunction

  // Bus pulled low at offset j (master or slave).
  function automatic bit bus_low(input logic [1:0] op, input logic b, input int j);
    return (j >= 1 && j <= low_len(op, b)) || (p_en && j >= p_lo && j <= p_hi);
  endfunction

  bit         m_act = 1'b0;
  int         m_acc = 0;
  logic [1:0] m_op = 2'b00;
  logic       m_bit = 1'b0;
  bit         m_pres = 1'b0;
  bit         pend_rst = 1'b1;

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      int  k;
      bit  e_drive, e_rv, e_ready;
      int  e_bit;
      if (pend_rst) begin
        m_act  = 1'b0;
        m_pres = 1'b0;
      end
      k       = cyc - m_acc;
      e_drive = m_act && k >= 1 && k <= low_len(m_op, m_bit);
      e_rv    = m_act && k == lat(m_op);
      e_ready = !(m_act && k >= 1 && k <= lat(m_op));
      // presence sample: 70us after release, bus seen through a 2-cycle synchroniser
      if (m_act && m_op == 2'b10 && k == 480 * C + 70 * C + 2)
        m_pres = bus_low(m_op, m_bit, 480 * C + 70 * C - 1);
      chk("drive_low", ow_drive_low, e_drive);
      chk("rsp_valid", ctl.rsp_valid, e_rv);
      chk("cmd_ready", ctl.cmd_ready, e_ready);
      chk("busy", ctl.busy, !e_ready);
      chk("presence", ctl.presence, m_pres);
      if (e_rv) begin
        case (m_op)
          2'b00:   e_bit = m_bit;
          2'b01:   e_bit = READ_EN ? !bus_low(m_op, m_bit, 15 * C - 1) : 0;
          2'b10:   e_bit = m_pres;
          default: e_bit = 0;
        endcase
        chk("rsp_bit", ctl.rsp_bit, e_bit);
      end
      if (ctl.cmd_valid && e_ready && !rst) begin
        m_act = 1'b1;
        m_acc = cyc;
        m_op  = ctl.cmd_op;
        m_bit = ctl.cmd_bit;
      end
      pend_rst = rst;
    end
  end

  // One operation with hand-computed latency, low-time and response bit.
  task automatic run_op(input string name, input logic [1:0] op, input logic b,
                        input bit pen, input int plo, input int phi, input bit keep,
                        input int x_lat, input int x_low, input int x_bit,
                        output int acc, output int rsp);
    int waited, low_cnt;
    bit got;
    @(posedge clk); #1;
    p_en = pen; p_lo = plo; p_hi = phi; s_acc = cyc;
    ctl.cmd_valid = 1'b1; ctl.cmd_op = op; ctl.cmd_bit = b;
    waited = 0; got = 1'b0;
    while (!got && waited < 10) begin
      @(negedge clk);
      if (ctl.cmd_ready) got = 1'b1; else waited++;
    end
    acc = cyc; rsp = cyc;
    if (!got) begin
      chk({name, "_accept"}, 0, 1);
      ctl.cmd_valid = 1'b0;
      return;
    end
    s_acc = cyc;
    if (!keep) begin
      @(posedge clk); #1;
      ctl.cmd_valid = 1'b0;
    end
    low_cnt = 0; got = 1'b0; waited = 0;
    while (!got && waited < 5000) begin
      @(negedge clk);
      waited++;
      if (ow_drive_low) low_cnt++;
      if (ctl.rsp_valid) got = 1'b1;
    end
    rsp = cyc;
    chk({name, "_rsp_seen"}, got, 1);
    chk({name, "_latency"}, rsp - acc, x_lat);
    chk({name, "_low_cycles"}, low_cnt, x_low);
    chk({name, "_rsp_bit"}, ctl.rsp_bit, x_bit);
  endtask

  initial begin
    int a0, r0, a1, r1, a2, r2, rv_seen;
    ctl.cmd_valid = 1'b0; ctl.cmd_op = 2'b00; ctl.cmd_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", ctl.cmd_ready, 1);
    chk("rst_busy", ctl.busy, 0);
    chk("rst_drive", ow_drive_low, 0);
    chk("rst_rsp_valid", ctl.rsp_valid, 0);
    chk("rst_rsp_bit", ctl.rsp_bit, 0);
    chk("rst_presence", ctl.presence, 0);

    run_op("write1", 2'b00, 1'b1, 0, 0, 0, 0, 281, 24, 1, a0, r0);
    run_op("write0", 2'b00, 1'b0, 0, 0, 0, 0, 281, 240, 0, a0, r0);
    if (READ_EN) begin
      run_op("read_rel", 2'b01, 1'b0, 0, 0, 0, 0, 281, 24, 1, a0, r0);
      run_op("read_low", 2'b01, 1'b0, 1, 25, 120, 0, 281, 24, 0, a0, r0);
    end else begin
      run_op("read_off", 2'b01, 1'b0, 0, 0, 0, 0, 2, 0, 0, a0, r0);
      run_op("read_off2", 2'b01, 1'b1, 1, 25, 120, 0, 2, 0, 0, a0, r0);
    end
    run_op("reset_pres", 2'b10, 1'b0, 1, 2000, 2400, 0, 3841, 1920, 1, a0, r0);
    chk("presence_set", ctl.presence, 1);
    run_op("reset_none", 2'b10, 1'b0, 0, 0, 0, 0, 3841, 1920, 0, a0, r0);
    chk("presence_clr", ctl.presence, 0);
    run_op("illegal", 2'b11, 1'b1, 0, 0, 0, 0, 2, 0, 0, a0, r0);

    // back-to-back with cmd_valid held
    run_op("b2b_0", 2'b00, 1'b1, 0, 0, 0, 1, 281, 24, 1, a0, r0);
    run_op("b2b_1", 2'b00, 1'b0, 0, 0, 0, 1, 281, 240, 0, a1, r1);
    run_op("b2b_2", 2'b00, 1'b1, 0, 0, 0, 0, 281, 24, 1, a2, r2);
    chk("b2b_gap1", a1 - r0, 1);
    chk("b2b_gap2", a2 - r1, 1);

    // abort a write-0 at cycle 100
    @(posedge clk); #1;
    p_en = 1'b0;
    ctl.cmd_valid = 1'b1; ctl.cmd_op = 2'b00; ctl.cmd_bit = 1'b0;
    @(negedge clk);
    chk("abort_accept", ctl.cmd_ready, 1);
    @(posedge clk); #1;
    ctl.cmd_valid = 1'b0;
    repeat (99) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_drive_before", ow_drive_low, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_drive_after", ow_drive_low, 0);
    chk("abort_ready_after", ctl.cmd_ready, 1);
    rv_seen = 0;
    repeat (400) begin
      @(negedge clk);
      if (ctl.rsp_valid) rv_seen++;
    end
    chk("abort_no_rsp", rv_seen, 0);
    run_op("recover", 2'b00, 1'b1, 0, 0, 0, 0, 281, 24, 1, a0, r0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
